// File: rtl/clk_pkg.sv
// clk_pkg: shared state encoding and default counter width for the clock-burst controller.
package clk_pkg;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, RUN, BURST, STEP} clk_burst_state_t;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for one request line; both flops reset to 0.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  always_ff @(posedge clk)
    if (reset) {r_meta, o_q} <= 2'b00;
    else       {r_meta, o_q} <= {i_d, r_meta};
endmodule

// File: rtl/clk_burst_ctl.sv
// clk_burst_ctl: free-run / counted-burst / single-step clock-enable generator.
// Define CLK_BURST_SYNC_EN to pass the four requests through two-flop synchronizers.
module clk_burst_ctl import clk_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_req,
  input  logic             stop_req,
  input  logic             burst_go,
  input  logic [CNT_W-1:0] burst_cnt,
  input  logic             step_go,
  output logic             gate_en,
  output logic             busy,
  output logic             burst_done,
  output logic [CNT_W-1:0] remaining
);
  logic w_run, w_stop, w_burst, w_step;
  clk_burst_state_t r_state;
`ifdef CLK_BURST_SYNC_EN
  sync2 u_sync_run   (.clk(clk), .reset(reset), .i_d(run_req),  .o_q(w_run));
  sync2 u_sync_stop  (.clk(clk), .reset(reset), .i_d(stop_req), .o_q(w_stop));
  sync2 u_sync_burst (.clk(clk), .reset(reset), .i_d(burst_go), .o_q(w_burst));
  sync2 u_sync_step  (.clk(clk), .reset(reset), .i_d(step_go),  .o_q(w_step));
`else
  assign w_run   = run_req;
  assign w_stop  = stop_req;
  assign w_burst = burst_go;
  assign w_step  = step_go;
`endif
  // remaining counts enables still owed, including the one issued in the current cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      gate_en    <= 1'b0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
      remaining  <= '0;
    end else begin
      burst_done <= 1'b0;
      case (r_state)
        IDLE:
          if (w_stop) begin
            r_state <= IDLE;
          end else if (w_burst) begin
            remaining <= burst_cnt;
            if (burst_cnt != '0) begin
              r_state <= BURST;
              gate_en <= 1'b1;
              busy    <= 1'b1;
            end else burst_done <= 1'b1;
          end else if (w_step) begin
            r_state <= STEP;
            gate_en <= 1'b1;
            busy    <= 1'b1;
          end else if (w_run) begin
            r_state <= RUN;
            gate_en <= 1'b1;
            busy    <= 1'b1;
          end
        RUN:
          if (w_stop || !w_run) begin
            r_state <= IDLE;
            gate_en <= 1'b0;
            busy    <= 1'b0;
          end
        BURST: begin
          remaining <= (remaining != '0) ? remaining - CNT_W'(1) : '0;
          if (w_stop || remaining <= CNT_W'(1)) begin
            r_state    <= IDLE;
            gate_en    <= 1'b0;
            busy       <= 1'b0;
            burst_done <= !w_stop;
          end
        end
        default: begin
          r_state <= IDLE;
          gate_en <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_clk_burst_ctl.sv
// tb_clk_burst_ctl: directed self-checking bench for clk_burst_ctl.
// Stimulus is in raw request time; output checks shift by the synchronizer latency when CLK_BURST_SYNC_EN is set.
module tb_clk_burst_ctl;
  localparam int W = 8;
`ifdef CLK_BURST_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic run_req = 1'b0, stop_req = 1'b0, burst_go = 1'b0, step_go = 1'b0;
  logic [W-1:0] burst_cnt = '0;
  logic gate_en, busy, burst_done;
  logic [W-1:0] remaining;
  int total = 0, bad = 0, n_en = 0, n_done = 0, e0, d0;

  clk_burst_ctl #(.CNT_W(W)) dut (
    .clk(clk), .reset(reset), .run_req(run_req), .stop_req(stop_req),
    .burst_go(burst_go), .burst_cnt(burst_cnt), .step_go(step_go),
    .gate_en(gate_en), .busy(busy), .burst_done(burst_done), .remaining(remaining)
  );

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (gate_en) n_en++;
    if (burst_done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tick(2);
    chk("rst_outs", 32'({gate_en, busy, burst_done, remaining}), 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outs", 32'({gate_en, busy, burst_done, remaining}), 0);
    end
    // burst of 5, cycle-exact
    burst_cnt = 8'd5;
    burst_go  = 1'b1;
    tick();
    burst_go = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      chk("burst_sync_delay", 32'(gate_en), 0);
      tick();
    end
    chk("burst_first", 32'({gate_en, busy, remaining}), 32'({2'b11, 8'd5}));
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("burst_run", 32'({gate_en, busy, burst_done, remaining}), 32'({3'b110, 8'(5 - i)}));
    end
    tick();
    chk("burst_done", 32'({gate_en, busy, burst_done, remaining}), 32'({3'b001, 8'd0}));
    tick();
    chk("done_one_cycle", 32'(burst_done), 0);
    // burst of 3 aborted after the 2nd enable
    e0 = n_en;
    d0 = n_done;
    burst_cnt = 8'd3;
    burst_go  = 1'b1;
    tick();
    burst_go = 1'b0;
    tick();
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    tick(LAT + 3);
    chk("abort_en", 32'(n_en - e0), 2);
    chk("abort_rem", 32'(remaining), 1);
    chk("abort_nodone", 32'(n_done - d0), 0);
    chk("abort_busy", 32'(busy), 0);
    // three spaced steps
    e0 = n_en;
    for (int i = 0; i < 3; i++) begin
      step_go = 1'b1;
      tick();
      step_go = 1'b0;
      tick(3);
    end
    tick(LAT + 1);
    chk("step_x3", 32'(n_en - e0), 3);
    step_go = 1'b1;
    tick();
    step_go = 1'b0;
    tick(LAT);
    chk("step_on", 32'({gate_en, busy}), 3);
    tick();
    chk("step_off", 32'({gate_en, busy}), 0);
    chk("step_rem", 32'(remaining), 1);
    e0 = n_en;
    step_go  = 1'b1;
    stop_req = 1'b1;
    tick();
    {step_go, stop_req} = 2'b00;
    tick(LAT + 3);
    chk("step_stop", 32'(n_en - e0), 0);
    // free-run 20 cycles with an ignored burst request
    e0 = n_en;
    d0 = n_done;
    run_req = 1'b1;
    tick(5);
    burst_cnt = 8'd7;
    burst_go  = 1'b1;
    tick();
    burst_go = 1'b0;
    tick(14);
    run_req = 1'b0;
    tick(LAT);
    chk("run_on", 32'(gate_en), 1);
    tick();
    chk("run_off", 32'({gate_en, busy}), 0);
    tick(3);
    chk("run_en", 32'(n_en - e0), 20);
    chk("run_nodone", 32'(n_done - d0), 0);
    chk("run_rem", 32'(remaining), 1);
    // zero-length burst
    e0 = n_en;
    burst_cnt = 8'd0;
    burst_go  = 1'b1;
    tick();
    burst_go = 1'b0;
    tick(LAT);
    chk("zero_done", 32'({gate_en, busy, burst_done, remaining}), 32'({3'b001, 8'd0}));
    tick();
    chk("zero_done_off", 32'(burst_done), 0);
    chk("zero_en", 32'(n_en - e0), 0);
    // reset after 4 enables of a 10-burst
    d0 = n_done;
    burst_cnt = 8'd10;
    burst_go  = 1'b1;
    tick();
    burst_go = 1'b0;
    tick(LAT + 3);
    chk("mid_rem", 32'({gate_en, remaining}), 32'({1'b1, 8'd7}));
    reset = 1'b1;
    tick();
    chk("mid_reset", 32'({gate_en, busy, burst_done, remaining}), 0);
    reset = 1'b0;
    tick(LAT + 12);
    chk("mid_nodone", 32'(n_done - d0), 0);
    chk("mid_idle", 32'({gate_en, busy}), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
